// File: rtl/slc3_mem_ctrl_if.sv
// slc3_mem_ctrl_if
//   Core-side memory port of the SLC-3 memory/IO controller.
//   master : the SLC-3 core (drives address/data/request, receives data/ready)
//   slave  : the controller
//   cpu_addr    16  word address
//   cpu_wdata   16  write data
//   cpu_mem_ena  1  access request (level)
//   cpu_wr_ena   1  1 = write, 0 = read
//   cpu_rdata   16  read data, held until the next read completes
//   cpu_ready    1  one-cycle completion pulse
interface slc3_mem_ctrl_if;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_mem_ena;
    logic        cpu_wr_ena;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;

    modport master (
        output cpu_addr, cpu_wdata, cpu_mem_ena, cpu_wr_ena,
        input  cpu_rdata, cpu_ready
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_mem_ena, cpu_wr_ena,
        output cpu_rdata, cpu_ready
    );
endinterface

// File: rtl/slc3_mem_ctrl.sv
// slc3_mem_ctrl
//   Memory/IO controller behind the SLC-3 core. After reset it copies
//   INIT_WORDS words from a synchronous program ROM into BRAM, then serves
//   one core access at a time: BRAM, the MMIO switch/hex register at IO_ADDR,
//   or an out-of-range address (writes dropped, reads return 0).
// Ports
//   clk, reset        clock, synchronous active-high reset
//   cpu               core port (slc3_mem_ctrl_if.slave)
//   init_done         high once the ROM copy finished, until reset
//   rom_addr/rdata    program ROM, data valid the cycle after the address
//   ram_*             BRAM port, read latency RAM_LAT
//   sw_i              switches, returned on reads of IO_ADDR
//   hex_o             hex display register, loaded by writes to IO_ADDR
module slc3_mem_ctrl #(
    parameter int          ADDR_W     = 10,
    parameter int          INIT_WORDS = 256,
    parameter int          RAM_LAT    = 1,
    parameter logic [15:0] IO_ADDR    = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    slc3_mem_ctrl_if.slave    cpu,
    output logic              init_done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              ram_ena,
    output logic              ram_we,
    input  logic [15:0]       ram_rdata,
    input  logic [15:0]       sw_i,
    output logic [15:0]       hex_o
);

    if (INIT_WORDS > 2**ADDR_W) begin : g_chk_init
        $error("slc3_mem_ctrl: INIT_WORDS exceeds BRAM size");
    end

    localparam int                WC_W      = $clog2(RAM_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(INIT_WORDS - 1);
    localparam logic [WC_W-1:0]   LAT_LAST  = WC_W'(RAM_LAT);

    typedef enum logic [2:0] {
        INIT_FETCH,
        INIT_STORE,
        IDLE,
        RAM_WAIT,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [15:0]       rdata_q, rdata_d;
    logic [15:0]       hex_q, hex_d;
    logic              done_q, done_d;
    logic              ready;

    // Upper address bits only feed the IO / out-of-range decode.
    logic        is_io;
    logic        is_oor;
    logic [31:0] addr_ext;

    assign addr_ext = 32'(cpu.cpu_addr);
    assign is_io    = (cpu.cpu_addr == IO_ADDR);
    assign is_oor   = ((addr_ext >> ADDR_W) != 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT_FETCH;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            hex_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        hex_d     = hex_q;
        done_d    = done_q;
        ready     = 1'b0;
        rom_addr  = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_ena   = 1'b0;
        ram_we    = 1'b0;

        case (state_q)
            INIT_FETCH: begin
                rom_addr = cnt_q;
                state_d  = INIT_STORE;
            end
            INIT_STORE: begin
                // ROM data for cnt_q arrived this cycle.
                ram_ena   = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = cnt_q;
                ram_wdata = rom_rdata;
                if (cnt_q == LAST_WORD) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = INIT_FETCH;
                end
            end
            IDLE: begin
                if (cpu.cpu_mem_ena) begin
                    addr_d  = cpu.cpu_addr[ADDR_W-1:0];
                    wdata_d = cpu.cpu_wdata;
                    we_d    = cpu.cpu_wr_ena;
                    wcnt_d  = '0;
                    if (is_io) begin
                        if (cpu.cpu_wr_ena) hex_d   = cpu.cpu_wdata;
                        else                rdata_d = sw_i;
                        state_d = RESP;
                    end else if (is_oor) begin
                        if (!cpu.cpu_wr_ena) rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        state_d = RAM_WAIT;
                    end
                end
            end
            RAM_WAIT: begin
                ram_ena  = 1'b1;
                ram_addr = addr_q;
                if (we_q) begin
                    ram_we    = 1'b1;
                    ram_wdata = wdata_q;
                    state_d   = RESP;
                end else if (wcnt_q == LAT_LAST) begin
                    // Address presented RAM_LAT cycles ago; data is valid now.
                    rdata_d = ram_rdata;
                    state_d = RESP;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            RESP: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = INIT_FETCH;
        endcase
    end

    assign cpu.cpu_rdata = rdata_q;
    assign cpu.cpu_ready = ready;
    assign init_done     = done_q;
    assign hex_o         = hex_q;

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
module tb_slc3_mem_ctrl;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              init_done;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic              ram_ena;
    logic              ram_we;
    logic [15:0]       ram_rdata;
    logic [15:0]       sw_i;
    logic [15:0]       hex_o;

    slc3_mem_ctrl_if cpu_bus ();

    slc3_mem_ctrl #(.ADDR_W(ADDR_W), .INIT_WORDS(256), .RAM_LAT(1), .IO_ADDR(16'hFFFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (cpu_bus),
        .init_done (init_done),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_ena   (ram_ena),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .sw_i      (sw_i),
        .hex_o     (hex_o)
    );

    always #5 clk = ~clk;

    // ROM / BRAM models and event counters.
    logic [15:0] mem [0:(2**ADDR_W)-1];
    int we_cnt  = 0;
    int en_cnt  = 0;
    int rdy_cnt = 0;

    function automatic logic [15:0] rom_val(input logic [ADDR_W-1:0] a);
        return 16'(a) ^ 16'hA5A5;
    endfunction

    always @(posedge clk) begin
        rom_rdata <= rom_val(rom_addr);
        if (ram_ena) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
        if (ram_we)            we_cnt  <= we_cnt + 1;
        if (ram_ena)           en_cnt  <= en_cnt + 1;
        if (cpu_bus.cpu_ready) rdy_cnt <= rdy_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One access: request sampled at edge k; returns cycles until ready (k+n).
    task automatic acc(input logic [15:0] a, input logic [15:0] d, input logic w,
                       output int lat, output int en_d);
        int en0;
        en0 = en_cnt;
        cpu_bus.cpu_addr    = a;
        cpu_bus.cpu_wdata   = d;
        cpu_bus.cpu_wr_ena  = w;
        cpu_bus.cpu_mem_ena = 1'b1;
        @(posedge clk);
        #1 cpu_bus.cpu_mem_ena = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            if (cpu_bus.cpu_ready) begin
                lat = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat == 0) chk("timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 chk("rdy_one_cycle", 32'(cpu_bus.cpu_ready), 32'd0);
        en_d = en_cnt - en0;
    endtask

    task automatic run_init(input string tag);
        int we0;
        int rdy0;
        we0  = we_cnt;
        rdy0 = rdy_cnt;
        repeat (511) @(posedge clk);
        #1 chk({tag, "_done_early"}, 32'(init_done), 32'd0);
        @(posedge clk);
        #1 chk({tag, "_done_512"}, 32'(init_done), 32'd1);
        chk({tag, "_we_pulses"}, 32'(we_cnt - we0), 32'd256);
        chk({tag, "_no_ready"}, 32'(rdy_cnt - rdy0), 32'd0);
    endtask

    initial begin
        int lat;
        int en_d;
        int bad;
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 16'h0000;
        reset               = 1'b1;
        sw_i                = 16'h0000;
        cpu_bus.cpu_addr    = '0;
        cpu_bus.cpu_wdata   = '0;
        cpu_bus.cpu_wr_ena  = 1'b0;
        cpu_bus.cpu_mem_ena = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(cpu_bus.cpu_ready), 32'd0);
        chk("rst_rdata", 32'(cpu_bus.cpu_rdata), 32'd0);
        chk("rst_done",  32'(init_done), 32'd0);
        chk("rst_hex",   32'(hex_o), 32'd0);
        chk("rst_ram",   {ram_ena, ram_we, 14'(ram_addr), ram_wdata}, 32'd0);
        chk("rst_rom",   32'(rom_addr), 32'd0);
        reset = 1'b0;

        // 1: ROM copy
        run_init("init");
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== rom_val(ADDR_W'(i))) bad++;
        chk("init_bram", 32'(bad), 32'd0);

        // 2: BRAM read
        acc(16'h0003, 16'h0, 1'b0, lat, en_d);
        chk("rd3_lat", 32'(lat), 32'd3);
        chk("rd3_data", 32'(cpu_bus.cpu_rdata), 32'hA5A6);

        // 3: BRAM write then read back; rdata holds across a write
        acc(16'h0010, 16'h1234, 1'b1, lat, en_d);
        chk("wr10_lat", 32'(lat), 32'd2);
        chk("wr10_mem", 32'(mem[16]), 32'h1234);
        acc(16'h0010, 16'h0, 1'b0, lat, en_d);
        chk("rd10_data", 32'(cpu_bus.cpu_rdata), 32'h1234);
        acc(16'h0020, 16'h5555, 1'b1, lat, en_d);
        chk("rdata_hold", 32'(cpu_bus.cpu_rdata), 32'h1234);

        // 4: MMIO
        acc(16'hFFFF, 16'hBEEF, 1'b1, lat, en_d);
        chk("io_wr_lat", 32'(lat), 32'd1);
        chk("io_hex", 32'(hex_o), 32'hBEEF);
        chk("io_wr_noram", 32'(en_d), 32'd0);
        sw_i = 16'h00C3;
        acc(16'hFFFF, 16'h0, 1'b0, lat, en_d);
        chk("io_rd_lat", 32'(lat), 32'd1);
        chk("io_rd_data", 32'(cpu_bus.cpu_rdata), 32'h00C3);

        // 5: out of range
        acc(16'h0400, 16'hDEAD, 1'b1, lat, en_d);
        chk("oor_wr_lat", 32'(lat), 32'd1);
        chk("oor_wr_noram", 32'(en_d), 32'd0);
        chk("oor_bram0", 32'(mem[0]), 32'hA5A5);
        acc(16'h0400, 16'h0, 1'b0, lat, en_d);
        chk("oor_rd_lat", 32'(lat), 32'd1);
        chk("oor_rd_data", 32'(cpu_bus.cpu_rdata), 32'h0000);

        // 6: reset during RAM_WAIT of a write
        cpu_bus.cpu_addr    = 16'h0030;
        cpu_bus.cpu_wdata   = 16'h7777;
        cpu_bus.cpu_wr_ena  = 1'b1;
        cpu_bus.cpu_mem_ena = 1'b1;
        @(posedge clk);
        #1 cpu_bus.cpu_mem_ena = 1'b0;
        chk("mid_we", 32'(ram_we), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abrt_we", 32'(ram_we), 32'd0);
        chk("abrt_ready", 32'(cpu_bus.cpu_ready), 32'd0);
        chk("abrt_hex", 32'(hex_o), 32'd0);
        chk("abrt_done", 32'(init_done), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        run_init("reinit");
        chk("reinit_mem30", 32'(mem[16'h30]), 32'(rom_val(ADDR_W'(16'h30))));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
